// File: rtl/serial_frame_capture_pkg.sv
// Shared types for the serial frame capture block.
package serial_frame_capture_pkg;
    `include "serial_frame_defs.vh"

    typedef enum logic [2:0] {
        S_WAIT_HI = ST_WAIT_HI,
        S_IDLE    = ST_IDLE,
        S_DATA    = ST_DATA,
        S_PARITY  = ST_PARITY,
        S_STOP    = ST_STOP
    } frame_state_t;
endpackage

// File: rtl/serial_frame_defs.vh
// State encodings and parity-mode constants for the serial frame capture/transmit blocks.
`ifndef SERIAL_FRAME_DEFS_VH
`define SERIAL_FRAME_DEFS_VH
localparam logic [2:0] ST_WAIT_HI = 3'd0;
localparam logic [2:0] ST_IDLE    = 3'd1;
localparam logic [2:0] ST_DATA    = 3'd2;
localparam logic [2:0] ST_PARITY  = 3'd3;
localparam logic [2:0] ST_STOP    = 3'd4;
localparam int PARITY_MODE_EVEN   = 0;
localparam int PARITY_MODE_ODD    = 1;
`endif

// File: rtl/sipo_shift_reg.sv
// LSB-first serial-in parallel-out register: first bit shifted in ends up in q[0].
module sipo_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              d_in,
    output logic [DATA_W-1:0] q
);
    // Shift towards the LSB so bit 0 of the frame lands in q[0] after DATA_W shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {d_in, q[DATA_W-1:1]};
        end else begin
            q <= q;
        end
    end
endmodule

// File: rtl/serial_frame_capture.sv
// Reassembles start/data/parity/stop frames from a one-bit-per-clock stream into a valid/ready word buffer.
module serial_frame_capture
    import serial_frame_capture_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_in,
    input  logic              out_ready,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic              busy,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    frame_state_t      state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              par_bit_r;
    logic [DATA_W-1:0] shift_q_s;
    logic              shift_en_s;
    logic [DATA_W-1:0] word_r;
    logic              word_valid_r;
    logic              busy_r;
    logic              parity_err_r;
    logic              frame_err_r;
    logic              overrun_r;

    function automatic logic expected_parity(input logic [DATA_W-1:0] data);
        return (^data) ^ (PARITY_ODD != 0);
    endfunction

    // Data bits are shifted exactly while the FSM sits in DATA.
    always_comb begin
        shift_en_s = 1'b0;
        if (state_r == S_DATA) begin
            shift_en_s = 1'b1;
        end else begin
            shift_en_s = 1'b0;
        end
    end

    sipo_shift_reg #(.DATA_W(DATA_W)) u_sipo (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en_s),
        .d_in     (d_in),
        .q        (shift_q_s)
    );

    // Frame FSM, bit counter, output buffer and error pulses; busy tracks the state it enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_WAIT_HI;
            cnt_r        <= '0;
            par_bit_r    <= 1'b0;
            word_r       <= '0;
            word_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            if (word_valid_r && out_ready) begin
                word_valid_r <= 1'b0;
            end
            case (state_r)
                S_WAIT_HI: begin
                    if (d_in) begin
                        state_r <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!d_in) begin
                        state_r <= S_DATA;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                S_DATA: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_BIT) begin
                        state_r <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    par_bit_r <= d_in;
                    state_r   <= S_STOP;
                end
                S_STOP: begin
                    busy_r  <= 1'b0;
                    state_r <= d_in ? S_IDLE : S_WAIT_HI;
                    // A consume on this same edge frees the buffer, so a good frame still loads.
                    if (!d_in) begin
                        frame_err_r <= 1'b1;
                    end else if ((PARITY_EN != 0) && (par_bit_r != expected_parity(shift_q_s))) begin
                        parity_err_r <= 1'b1;
                    end else if (word_valid_r && !out_ready) begin
                        overrun_r <= 1'b1;
                    end else begin
                        word_r       <= shift_q_s;
                        word_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_WAIT_HI;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign word_out   = word_r;
    assign word_valid = word_valid_r;
    assign busy       = busy_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
endmodule

// File: tb/tb_serial_frame_capture.sv
// Directed self-checking bench for serial_frame_capture (DATA_W=8, even parity).
module tb_serial_frame_capture;
    logic       clk;
    logic       rst;
    logic       d_in;
    logic       out_ready;
    logic [7:0] word_out;
    logic       word_valid;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int tests_run;
    int tests_failed;

    serial_frame_capture #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .out_ready  (out_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One serial bit per clock; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic b);
        d_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop, input logic rdy_stop);
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(data[i]);
        drive(par);
        out_ready = rdy_stop;
        drive(stop);
        out_ready = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        drive(1'b1);
        out_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        d_in      = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_word", {24'd0, word_out}, 32'h0);
        check("rst_valid", {31'd0, word_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errs", {29'd0, parity_err, frame_err, overrun}, 32'd0);

        // 1: good 0xA5 frame, held, then consumed
        drive(1'b1);
        drive(1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("t1_word", {24'd0, word_out}, 32'hA5);
        check("t1_valid", {31'd0, word_valid}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_perr", {31'd0, parity_err}, 32'd0);
        consume();
        check("t1_consumed", {31'd0, word_valid}, 32'd0);

        // 2: wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check("t2_perr", {31'd0, parity_err}, 32'd1);
        check("t2_valid", {31'd0, word_valid}, 32'd0);
        check("t2_word", {24'd0, word_out}, 32'hA5);
        drive(1'b1);
        check("t2_perr_pulse", {31'd0, parity_err}, 32'd0);

        // 3: framing error, stuck-low line, then recovery
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        check("t3_ferr", {31'd0, frame_err}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_valid", {31'd0, word_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0);
            check("t3_low_busy", {31'd0, busy}, 32'd0);
            check("t3_low_ferr", {31'd0, frame_err}, 32'd0);
        end
        drive(1'b1);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        check("t3_word", {24'd0, word_out}, 32'h33);
        check("t3_valid2", {31'd0, word_valid}, 32'd1);
        consume();

        // 4: back-to-back with buffer full -> overrun, old word kept
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        check("t4_word1", {24'd0, word_out}, 32'h3C);
        check("t4_ovr1", {31'd0, overrun}, 32'd0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        check("t4_ovr", {31'd0, overrun}, 32'd1);
        check("t4_word2", {24'd0, word_out}, 32'h3C);
        check("t4_valid", {31'd0, word_valid}, 32'd1);
        drive(1'b1);
        check("t4_ovr_pulse", {31'd0, overrun}, 32'd0);
        consume();

        // 5: consume on the same edge the second frame completes
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        check("t5_word", {24'd0, word_out}, 32'hC3);
        check("t5_valid", {31'd0, word_valid}, 32'd1);
        check("t5_ovr", {31'd0, overrun}, 32'd0);
        consume();
        check("t5_consumed", {31'd0, word_valid}, 32'd0);

        // 6: reset in the middle of a frame, then a low line must not arm
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        check("t6_busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        drive(1'b0);
        rst = 1'b0;
        check("t6_word", {24'd0, word_out}, 32'h0);
        check("t6_valid", {31'd0, word_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_errs", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0);
            check("t6_low_busy", {31'd0, busy}, 32'd0);
        end
        check("t6_low_errs", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        drive(1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("t6_word2", {24'd0, word_out}, 32'h5A);
        check("t6_valid2", {31'd0, word_valid}, 32'd1);
        consume();

        // Odd number of ones needs parity bit 1 under even parity
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check("odd_word", {24'd0, word_out}, 32'h07);
        check("odd_perr", {31'd0, parity_err}, 32'd0);
        check("odd_valid", {31'd0, word_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
